if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS core, combining the PC register and the IF/ID pipeline register.
- Drives the instruction ROM, then presents `pc` and `inst` to the decoder.
- Consumes the decoder's branch redirect (`branch_flag`, `branch_target_address`). The redirect follows MIPS delay-slot semantics: the instruction already fetched after a branch always reaches ID.
- Also accepts a flush/redirect from the exception path and honours pipeline stalls.

Parameters:
- PC_RESET, 32'h0000_0000, fetch address after reset.
- PC_STEP, 4, increment per sequential fetch.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall_if  in  1  freeze PC
- stall_id  in  1  freeze IF/ID register
- branch_flag_i  in  1  redirect request from ID
- branch_target_address_i  in  32  redirect target from ID
- flush_i  in  1  exception/flush redirect, highest priority
- new_pc_i  in  32  flush target
- rom_ce_o  out  1  ROM chip enable
- rom_addr_o  out  32  ROM address (= pc)
- rom_data_i  in  32  ROM read data, combinational (same cycle as rom_addr_o)
- id_pc_o  out  32  PC of instruction in ID
- id_inst_o  out  32  instruction in ID
- id_valid_o  out  1  ID holds a real instruction (0 = bubble)
- fetch_count_o  out  32  count of instructions delivered to ID

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - pc=PC_RESET, state=IDLE, rom_ce_o=0.
  - id_pc_o=0, id_inst_o=0, id_valid_o=0, fetch_count_o=0.
  - Reset asserted mid-stream discards any stall, branch or flush in that cycle.
- State machine:
  - IDLE: rom_ce_o=0, pc held at PC_RESET. The next edge (rst=0) moves to RUN.
  - RUN: rom_ce_o=1 and stays there until rst.
  - No other states.
- rom_addr_o = pc at all times. The ROM is qualified by rom_ce_o.
- PC update at each edge in RUN, in priority order:
  1. flush_i → pc=new_pc_i.
  2. stall_if → hold pc.
  3. branch_flag_i → pc=branch_target_address_i.
  4. otherwise pc=pc+PC_STEP.
- In IDLE, pc holds PC_RESET regardless of other inputs, so the first fetch after reset is at PC_RESET.
- Targets with bits[1:0]≠0: those bits are forced to 00 when loaded. Address-error detection is not done here.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- IF/ID register update at each edge, in priority order:
  1. flush_i → bubble (pc 0, inst 0, valid 0).
  2. stall_if=1, stall_id=1 → hold all three outputs.
  3. stall_if=1, stall_id=0 → bubble.
  4. rom_ce_o=0 → bubble.
  5. otherwise capture {pc, rom_data_i, 1}.
- Stall combination stall_id=1 with stall_if=0 is illegal. It is treated as stall_if=1 for both pc and IF/ID.
- Branch timing:
  - A branch in ID at cycle N redirects pc at edge N.
  - The delay-slot instruction, fetched in cycle N, enters ID at edge N.
  - The target instruction enters ID at edge N+1.
  - No squash is performed.
- branch_flag_i while stall_if=1 is ignored. ID must hold the branch and reassert branch_flag_i on the unstalled cycle.
- branch_flag_i and flush_i in the same cycle: flush wins and the branch is dropped.
- fetch_count_o increments by 1 on each edge where valid=1 is captured (case 5 above). It wraps at 2^32 and holds on stall, bubble and flush.
- Latency: fetch address to ID output is 1 edge. Redirect to first target instruction in ID is 2 edges.

Decomposition:
- Shared defines (existing defines file):
  - PC_RESET default tied to InitialPc.
  - ZeroWord, RstEnable, Stop/NoStop, Branch/NotBranch, ChipEnable/ChipDisable.
  - New constants IF_ST_IDLE and IF_ST_RUN.
- One natural sub-module: if_id_reg (the IF/ID register with the bubble/hold/capture logic).
- The PC/FSM logic stays in if_stage.

Test Plan:
- Reset then release, rom_data_i=32'h3401_0001 at 0x0: IDLE for 1 cycle with ce=0, then addr 0x0 then 0x4. ID gets pc=0x0, inst=32'h3401_0001, valid=1; fetch_count_o=1.
- Branch at pc 0x8 in ID asserting branch_flag_i with target 0x40: rom_addr_o shows 0xC then 0x40. ID receives the 0xC delay slot, then 0x40; no bubble between them.
- stall_if=stall_id=1 for 3 cycles at pc 0x10: rom_addr_o holds 0x10 and ID outputs are frozen. With stall_if=1, stall_id=0 for 1 cycle, ID shows valid=0 and inst=0, and fetch_count_o is unchanged.
- flush_i=1 with new_pc_i=0x180 together with branch_flag_i=1 and target 0x40: pc becomes 0x180 and ID gets a bubble. The next ID instruction is at 0x180.
- pc=32'hFFFF_FFFC, no stall: next rom_addr_o=0x0. Separately, branch target 0x43 loads pc=0x40.
- rst=1 asserted while stall_if=1 and branch_flag_i=1: next cycle pc=PC_RESET, ce=0, all ID outputs 0 and fetch_count_o=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] InitialPc   = 32'h0000_0000;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;
  localparam logic        Branch      = 1'b1;
  localparam logic        NotBranch   = 1'b0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  typedef enum logic {
    IF_ST_IDLE = 1'b0,
    IF_ST_RUN  = 1'b1
  } if_state_e;

  // Misaligned redirect targets are silently truncated to a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word, inserts bubbles, holds on ID stall.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        ce_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] id_pc_p1;
  logic [31:0] id_inst_p1;
  logic        vld_p1;
  logic [31:0] cnt_p1;

  // stall_id alone is treated as a full stall, so it always means hold.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      id_pc_p1   <= ZeroWord;
      id_inst_p1 <= ZeroWord;
      vld_p1     <= 1'b0;
      cnt_p1     <= ZeroWord;
    end else if (flush_i) begin
      id_pc_p1   <= ZeroWord;
      id_inst_p1 <= ZeroWord;
      vld_p1     <= 1'b0;
    end else if (stall_id == Stop) begin
      id_pc_p1   <= id_pc_p1;
      id_inst_p1 <= id_inst_p1;
      vld_p1     <= vld_p1;
    end else if (stall_if == Stop || ce_i == ChipDisable) begin
      id_pc_p1   <= ZeroWord;
      id_inst_p1 <= ZeroWord;
      vld_p1     <= 1'b0;
    end else begin
      id_pc_p1   <= pc_i;
      id_inst_p1 <= inst_i;
      vld_p1     <= 1'b1;
      cnt_p1     <= cnt_p1 + 32'd1;
    end
  end

  assign id_pc_o       = id_pc_p1;
  assign id_inst_o     = id_inst_p1;
  assign id_valid_o    = vld_p1;
  assign fetch_count_o = cnt_p1;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with IDLE/RUN control, feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = InitialPc,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_count_o
);

  if_state_e   state_q;
  if_state_e   state_d;
  logic [31:0] pc_p0;
  logic [31:0] pc_d;
  logic        ce;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IF_ST_IDLE;
      pc_p0   <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
    end
  end

  // Flush beats stall beats branch; a branch seen during a stall is dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    ce      = ChipDisable;
    case (state_q)
      IF_ST_IDLE: begin
        state_d = IF_ST_RUN;
        pc_d    = PC_RESET;
      end
      IF_ST_RUN: begin
        ce = ChipEnable;
        if (flush_i)
          pc_d = word_align(new_pc_i);
        else if (stall_if == Stop || stall_id == Stop)
          pc_d = pc_p0;
        else if (branch_flag_i == Branch)
          pc_d = word_align(branch_target_address_i);
        else
          pc_d = pc_p0 + PC_STEP;
      end
    endcase
  end

  assign rom_ce_o   = ce;
  assign rom_addr_o = pc_p0;

  // ---- IF -> ID boundary ----
  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .ce_i         (ce),
    .pc_i         (pc_p0),
    .inst_i       (rom_data_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_valid_o   (id_valid_o),
    .fetch_count_o(fetch_count_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model predicts the state after each edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        stall_id = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [31:0] fetch_count_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_vld;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model state: architectural view, not RTL encoding
  logic [31:0] m_pc;
  logic        m_running;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_vld;
  logic [31:0] m_cnt;
  bit          m_known = 0;

  if_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_if               (stall_if),
    .stall_id               (stall_id),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .flush_i                (flush_i),
    .new_pc_i               (new_pc_i),
    .rom_ce_o               (rom_ce_o),
    .rom_addr_o             (rom_addr_o),
    .rom_data_i             (rom_data_i),
    .id_pc_o                (id_pc_o),
    .id_inst_o              (id_inst_o),
    .id_valid_o             (id_valid_o),
    .fetch_count_o          (fetch_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h3401_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_data_i = rom_fn(rom_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: one expected snapshot per edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rom_addr", rom_addr_o, e.pc);
      chk("rom_ce", {31'b0, rom_ce_o}, {31'b0, e.ce});
      chk("id_pc", id_pc_o, e.id_pc);
      chk("id_inst", id_inst_o, e.id_inst);
      chk("id_valid", {31'b0, id_valid_o}, {31'b0, e.id_vld});
      chk("fetch_count", fetch_count_o, e.cnt);
    end
  end

  task automatic cycle(input logic r, input logic sif, input logic sid, input logic br,
                       input logic [31:0] bta, input logic fl, input logic [31:0] npc);
    exp_t e;
    logic [31:0] fetched;
    @(negedge clk);
    rst = r; stall_if = sif; stall_id = sid; branch_flag_i = br;
    branch_target_address_i = bta; flush_i = fl; new_pc_i = npc;
    if (r) begin
      m_pc = 32'h0; m_running = 0;
      m_id_pc = 0; m_id_inst = 0; m_id_vld = 0; m_cnt = 0;
      m_known = 1;
    end else if (m_known) begin
      fetched = rom_fn(m_pc);
      // what ID sees after the edge
      if (fl) begin
        m_id_pc = 0; m_id_inst = 0; m_id_vld = 0;
      end else if (sid) begin
        // frozen
      end else if (sif || !m_running) begin
        m_id_pc = 0; m_id_inst = 0; m_id_vld = 0;
      end else begin
        m_id_pc = m_pc; m_id_inst = fetched; m_id_vld = 1; m_cnt = m_cnt + 1;
      end
      // where fetch goes next
      if (m_running) begin
        if (fl) m_pc = npc & ~32'h3;
        else if (!(sif || sid)) m_pc = br ? (bta & ~32'h3) : m_pc + 32'd4;
      end
      m_running = 1;
    end
    if (m_known) begin
      e.pc = m_pc; e.ce = m_running; e.id_pc = m_id_pc;
      e.id_inst = m_id_inst; e.id_vld = m_id_vld; e.cnt = m_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    int wait_cnt;
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle(1, 0, 0, 0, 32'h0, 0, 32'h0);
    run(4);                                           // ID now holds 0x8
    cycle(0, 0, 0, 1, 32'h0000_0040, 0, 32'h0);       // branch: delay slot 0xC follows
    run(3);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 32'h0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0, 0, 32'h0);               // bubble into ID
    run(2);
    cycle(0, 0, 0, 1, 32'h0000_0040, 1, 32'h0000_0180); // flush beats branch
    run(3);
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    run(3);                                           // wraps to 0x0
    cycle(0, 0, 0, 1, 32'h0000_0043, 0, 32'h0);       // misaligned target
    run(2);
    cycle(0, 0, 1, 1, 32'h0000_0200, 0, 32'h0);       // stall_id alone = full stall
    cycle(0, 1, 0, 1, 32'h0000_0300, 0, 32'h0);       // branch ignored under stall
    run(2);
    cycle(1, 1, 0, 1, 32'h0000_0040, 0, 32'h0);       // reset overrides everything
    run(3);

    for (int i = 0; i < 400; i++) begin
      logic r, sif, sid, br, fl;
      r   = ($urandom_range(63) == 0);
      fl  = ($urandom_range(15) == 0);
      sif = ($urandom_range(4) == 0);
      sid = sif ? ($urandom_range(1) == 0) : ($urandom_range(19) == 0);
      br  = ($urandom_range(5) == 0);
      cycle(r, sif, sid, br, $urandom, fl, $urandom);
    end
    cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
